multicycle_processor: RTL

Parametrised multi-cycle successor to the team's single-cycle 8-bit core. One control FSM sequences fetch, decode, execute, memory and writeback over one clock. It drives a synchronous instruction ROM and a handshaked data memory. It holds an 8-entry register file of DATA_W bits and adds branch, jump, halt and memory wait-state support.

---
 rtl/multicycle_processor.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/multicycle_processor.sv
// multicycle_processor: multi-cycle core with a synchronous instruction ROM
// and a handshaked data memory. It has an 8-entry register file and supports
// branch, jump, halt and data-memory wait states.
// Optional feature macro: ILLEGAL_TRAP_EN. When it is defined, opcodes 14/15
// halt the core. When it is undefined, they retire as NOP. In both cases the
// sticky illegal flag is set.
module multicycle_processor #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [15:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic [PC_W-1:0]   pc_out,
    output logic [DATA_W-1:0] proc_out,
    output logic              halted,
    output logic              illegal
);

    // state  | meaning
    // FETCH  | imem_addr=pc, ROM word arrives next cycle
    // DECODE | latch ir, resolve NOP/JMP/HALT/illegal
    // EXEC   | ALU result, memory address, or branch
    // MEM    | dmem_req held until dmem_ack
    // WB     | write rd, advance pc
    // HALT   | terminal until reset
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    localparam logic [3:0] OP_NOP  = 4'd0,  OP_ADD = 4'd1,  OP_SUB  = 4'd2,  OP_AND = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4,  OP_XOR = 4'd5,  OP_SLL  = 4'd6,  OP_SRL = 4'd7;
    localparam logic [3:0] OP_ADDI = 4'd8,  OP_LW  = 4'd9,  OP_SW   = 4'd10, OP_BEQ = 4'd11;
    localparam logic [3:0] OP_JMP  = 4'd12, OP_HALT = 4'd13;

    state_t            state;
    logic [PC_W-1:0]   pc;
    logic [15:0]       ir;
    logic [DATA_W-1:0] regs [8];
    logic [DATA_W-1:0] result;

    logic [DATA_W-1:0] rd_val, rs_val, imm_d, alu, ea;
    logic [PC_W-1:0]   imm_p;

    assign imem_addr = pc;
    assign pc_out    = pc;

    // The register file cannot change between DECODE and WB, so operands
    // are read directly from it using the latched ir.
    assign rd_val = regs[ir[11:9]];
    assign rs_val = regs[ir[8:6]];
    assign imm_d  = DATA_W'($signed(ir[5:0]));
    assign imm_p  = PC_W'($signed(ir[5:0]));
    assign ea     = rs_val + imm_d;

    // ALU result for the register-writing ops.
    always_comb begin
        alu = '0;
        case (ir[15:12])
            OP_ADD:  alu = rd_val + rs_val;
            OP_SUB:  alu = rd_val - rs_val;
            OP_AND:  alu = rd_val & rs_val;
            OP_OR:   alu = rd_val | rs_val;
            OP_XOR:  alu = rd_val ^ rs_val;
            OP_SLL:  alu = (int'(ir[4:0]) >= DATA_W) ? '0 : rd_val << ir[4:0];
            OP_SRL:  alu = (int'(ir[4:0]) >= DATA_W) ? '0 : rd_val >> ir[4:0];
            OP_ADDI: alu = rd_val + imm_d;
            default: alu = '0;
        endcase
    end

    // Control FSM with the datapath registers and the registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_FETCH;
            pc         <= '0;
            ir         <= '0;
            result     <= '0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            proc_out   <= '0;
            halted     <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            case (state)
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    ir <= imem_rdata;
                    case (imem_rdata[15:12])
                        OP_NOP: begin
                            pc    <= pc + PC_W'(1);
                            state <= S_FETCH;
                        end
                        OP_JMP: begin
                            pc    <= PC_W'(imem_rdata[5:0]);
                            state <= S_FETCH;
                        end
                        OP_HALT: begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end
                        4'd14, 4'd15: begin
                            illegal <= 1'b1;
`ifdef ILLEGAL_TRAP_EN
                            halted  <= 1'b1;
                            state   <= S_HALT;
`else
                            pc      <= pc + PC_W'(1);
                            state   <= S_FETCH;
`endif
                        end
                        default: state <= S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    case (ir[15:12])
                        OP_BEQ: begin
                            pc    <= (rd_val == rs_val) ? pc + PC_W'(1) + imm_p : pc + PC_W'(1);
                            state <= S_FETCH;
                        end
                        OP_LW, OP_SW: begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= (ir[15:12] == OP_SW);
                            dmem_addr  <= ADDR_W'(ea);
                            dmem_wdata <= rd_val;
                            state      <= S_MEM;
                        end
                        default: begin
                            result <= alu;
                            state  <= S_WB;
                        end
                    endcase
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        if (dmem_we) begin
                            pc    <= pc + PC_W'(1);
                            state <= S_FETCH;
                        end else begin
                            result <= dmem_rdata;
                            state  <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    regs[ir[11:9]] <= result;
                    if (ir[11:9] == 3'd7) proc_out <= result;
                    pc    <= pc + PC_W'(1);
                    state <= S_FETCH;
                end
                S_HALT: state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule
